// File: rtl/vp_pkg.sv
// vp_pkg: shared types and width helpers for the video-pipe frame sequencer.
//   vp_frame_state_t : frame sequencer states
//   col_width/row_width : counter width helpers
//   DW_DEFAULT : default pixel data width
package vp_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAD_TOP = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_PAD_BOT = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } vp_frame_state_t;

    // Column counter only needs to reach RL-1.
    function automatic int col_width(input int rl);
        return (rl > 1) ? $clog2(rl) : 1;
    endfunction

    // Row counter runs one past the last row after the final window wraps.
    function automatic int row_width(input int nrows);
        return $clog2(nrows + 2);
    endfunction

endpackage

// File: rtl/vp_win_pos_counter.sv
// vp_win_pos_counter: row/column position of the next 3x3 window.
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : synchronous clear to (0,0)
//   i_inc        : advance one window (col wraps RL-1 -> 0 with row+1)
//   o_row, o_col : current position (registered)
//   o_last       : position is (NROWS-1, RL-1)
//   o_border     : position lies on the frame edge
module vp_win_pos_counter
    import vp_pkg::*;
#(
    parameter int RL    = 640,
    parameter int NROWS = 480,
    parameter int CW    = col_width(RL),
    parameter int RW    = row_width(NROWS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last,
    output logic          o_border
);

    logic col_end;

    assign col_end = (o_col == CW'(RL - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_row <= '0;
            o_col <= '0;
        end else if (i_clr) begin
            o_row <= '0;
            o_col <= '0;
        end else if (i_inc) begin
            if (col_end) begin
                o_col <= '0;
                o_row <= o_row + RW'(1);
            end else begin
                o_col <= o_col + CW'(1);
            end
        end
    end

    assign o_last   = (o_row == RW'(NROWS - 1)) && col_end;
    assign o_border = (o_row == '0) || (o_row == RW'(NROWS - 1)) ||
                      (o_col == '0) || col_end;

endmodule

// File: rtl/vp_frame_ctrl.sv
// vp_frame_ctrl: frame sequencer ahead of the 3x3 window generator.
// Wraps each camera frame with one zero row above and below, forwards
// camera pixels with one cycle of latency, tracks the position of every
// window the generator emits and flags protocol errors. Never stalls.
//   i_clk, i_rst                : clock, async active-high reset
//   i_vsync                     : frame-start pulse
//   i_pixel_data/i_pixel_valid  : camera stream
//   o_lb_data/o_lb_valid        : stream to the line buffers (registered)
//   i_win_valid                 : generator emits a window this cycle
//   o_win_row/o_win_col         : position of that window
//   o_win_border/o_win_last     : edge / final-window flags (qualified)
//   o_frame_done                : one-cycle pulse after the last window
//   o_busy                      : sequencer not idle
//   o_err/i_err_clr             : sticky protocol error and its clear
module vp_frame_ctrl
    import vp_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int RL    = 640,
    parameter int NROWS = 480,
    parameter int CW    = col_width(RL),
    parameter int RW    = row_width(NROWS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_vsync,
    input  logic [DW-1:0] i_pixel_data,
    input  logic          i_pixel_valid,
    output logic [DW-1:0] o_lb_data,
    output logic          o_lb_valid,
    input  logic          i_win_valid,
    output logic [RW-1:0] o_win_row,
    output logic [CW-1:0] o_win_col,
    output logic          o_win_border,
    output logic          o_win_last,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_err,
    input  logic          i_err_clr
);

    localparam int PIX = NROWS * RL;
    localparam int IW  = $clog2(PIX + 1);

    vp_frame_state_t state, state_nxt;
    logic [IW-1:0]   in_cnt;
    logic [CW-1:0]   inj_cnt;
    logic            inj_end, pix_acc, pix_last, err_set;
    logic            pos_clr, win_adv, pos_last, pos_border;

    assign inj_end  = (inj_cnt == CW'(RL - 1));
    assign pix_acc  = (state == ST_ACTIVE) && i_pixel_valid;
    assign pix_last = pix_acc && (in_cnt == IW'(PIX - 1));

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_vsync) state_nxt = ST_PAD_TOP;
                if (i_win_valid) err_set = 1'b1;
            end
            ST_PAD_TOP: begin
                if (inj_end) state_nxt = ST_ACTIVE;
                if (i_pixel_valid || i_vsync || i_win_valid) err_set = 1'b1;
            end
            ST_ACTIVE: begin
                if (pix_last) state_nxt = ST_PAD_BOT;
                if (i_vsync) err_set = 1'b1;
            end
            ST_PAD_BOT: begin
                if (inj_end) state_nxt = ST_DRAIN;
                if (i_pixel_valid || i_vsync) err_set = 1'b1;
            end
            ST_DRAIN: begin
                if (i_win_valid && pos_last) state_nxt = ST_DONE;
                if (i_pixel_valid || i_vsync) err_set = 1'b1;
            end
            ST_DONE: begin
                state_nxt = i_vsync ? ST_PAD_TOP : ST_IDLE;
                if (i_win_valid) err_set = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Zero-row injection counter, runs only while padding.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inj_cnt <= '0;
        end else if (state == ST_PAD_TOP || state == ST_PAD_BOT) begin
            inj_cnt <= inj_end ? '0 : inj_cnt + CW'(1);
        end else begin
            inj_cnt <= '0;
        end
    end

    assign pos_clr = (state_nxt == ST_PAD_TOP) && (state != ST_PAD_TOP);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        in_cnt <= '0;
        else if (pos_clr) in_cnt <= '0;
        else if (pix_acc) in_cnt <= in_cnt + IW'(1);
    end

    // Padding and camera pixels share one register stage so the zero rows
    // butt up against the frame with no gap or overlap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_lb_valid <= 1'b0;
            o_lb_data  <= '0;
        end else begin
            case (state)
                ST_PAD_TOP, ST_PAD_BOT: begin
                    o_lb_valid <= 1'b1;
                    o_lb_data  <= '0;
                end
                ST_ACTIVE: begin
                    o_lb_valid <= i_pixel_valid;
                    o_lb_data  <= i_pixel_valid ? i_pixel_data : '0;
                end
                default: begin
                    o_lb_valid <= 1'b0;
                    o_lb_data  <= '0;
                end
            endcase
        end
    end

    // Set wins over clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          o_err <= 1'b0;
        else if (err_set)   o_err <= 1'b1;
        else if (i_err_clr) o_err <= 1'b0;
    end

    // Windows only advance the position once real rows can be flowing.
    assign win_adv = i_win_valid &&
                     (state == ST_ACTIVE || state == ST_PAD_BOT || state == ST_DRAIN);

    vp_win_pos_counter #(
        .RL    (RL),
        .NROWS (NROWS),
        .CW    (CW),
        .RW    (RW)
    ) u_pos (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (pos_clr),
        .i_inc    (win_adv),
        .o_row    (o_win_row),
        .o_col    (o_win_col),
        .o_last   (pos_last),
        .o_border (pos_border)
    );

    assign o_win_last   = i_win_valid && pos_last;
    assign o_win_border = i_win_valid && pos_border;
    assign o_frame_done = (state == ST_DONE);
    assign o_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_vp_frame_ctrl.sv
// Bench for vp_frame_ctrl (RL=8, NROWS=4): directed frames with a simple
// window-generator stand-in, a count-based reference model checked every
// cycle, and literal expectations per scenario.
module tb_vp_frame_ctrl;

    localparam int DW = 8, RL = 8, NROWS = 4, CW = 3, RW = 3, N = NROWS * RL;

    logic          clk = 1'b0, rst = 1'b1, vsync = 1'b0, pv = 1'b0, wv = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [DW-1:0] o_lb_data;
    logic          o_lb_valid, o_win_border, o_win_last, o_frame_done, o_busy, o_err;
    logic [RW-1:0] o_win_row;
    logic [CW-1:0] o_win_col;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    vp_frame_ctrl #(.DW(DW), .RL(RL), .NROWS(NROWS)) dut (
        .i_clk(clk), .i_rst(rst), .i_vsync(vsync), .i_pixel_data(pd), .i_pixel_valid(pv),
        .o_lb_data(o_lb_data), .o_lb_valid(o_lb_valid), .i_win_valid(wv),
        .o_win_row(o_win_row), .o_win_col(o_win_col), .o_win_border(o_win_border),
        .o_win_last(o_win_last), .o_frame_done(o_frame_done), .o_busy(o_busy),
        .o_err(o_err), .i_err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Window-generator stand-in: one window per line-buffer pixel, lagging
    // the padded stream by two rows, so 48 padded pixels give 32 windows.
    int lbcnt = 0;
    bit force_wv = 1'b0;
    always @(negedge clk) begin
        #1;
        wv = force_wv || (o_lb_valid && lbcnt >= 2 * RL);
        if (o_frame_done || !o_busy) lbcnt = 0;
        else if (o_lb_valid) lbcnt++;
    end

    // Reference model in terms of what is left of the frame.
    bit          m_busy, m_done, m_err, m_lbv;
    logic [7:0]  m_lbd;
    int          m_top, m_pix, m_bot, m_wins;

    function automatic void m_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_lbv = 0; m_lbd = '0;
        m_top = 0; m_pix = 0; m_bot = 0; m_wins = 0;
    endfunction

    function automatic void m_start();
        m_busy = 1; m_top = RL; m_pix = N; m_bot = RL; m_wins = 0;
    endfunction

    function automatic void m_step(input bit vs, input bit p, input bit w, input bit ec,
                                   input logic [7:0] d);
        bit es = 0;
        m_lbv = 0; m_lbd = '0;
        if (!m_busy) begin
            if (w) es = 1;
            if (vs) m_start();
        end else if (m_done) begin
            if (w) es = 1;
            m_done = 0; m_busy = 0;
            if (vs) m_start();
        end else begin
            if (vs) es = 1;
            if (m_top > 0) begin
                if (p || w) es = 1;
                m_lbv = 1; m_top--;
            end else if (m_pix > 0) begin
                if (p) begin m_lbv = 1; m_lbd = d; m_pix--; end
                if (w) m_wins++;
            end else if (m_bot > 0) begin
                if (p) es = 1;
                m_lbv = 1; m_bot--;
                if (w) m_wins++;
            end else begin
                if (p) es = 1;
                if (w) begin
                    if (m_wins == N - 1) m_done = 1;
                    m_wins++;
                end
            end
        end
        if (es) m_err = 1;
        else if (ec) m_err = 0;
    endfunction

    // Per-scenario recordings
    logic [7:0]    lbq[$];
    int            win_n, bord_n, last_n, done_n;
    logic [RW-1:0] last_row;
    logic [CW-1:0] last_col;

    initial begin : compare
        int er, ecol;
        bit eb;
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else m_step(vsync, pv, wv, err_clr, pd);
            @(negedge clk);
            #2;
            if (rst) m_reset();
            er   = m_wins / RL;
            ecol = m_wins % RL;
            eb   = wv && (er == 0 || er == NROWS - 1 || ecol == 0 || ecol == RL - 1);
            chk("lb_valid", o_lb_valid, m_lbv);
            chk("lb_data", o_lb_data, m_lbd);
            chk("win_row", o_win_row, er);
            chk("win_col", o_win_col, ecol);
            chk("win_border", o_win_border, eb);
            chk("win_last", o_win_last, wv && m_wins == N - 1);
            chk("frame_done", o_frame_done, m_done);
            chk("busy", o_busy, m_busy);
            chk("err", o_err, m_err);
            if (o_lb_valid) lbq.push_back(o_lb_data);
            if (wv) begin
                win_n++;
                if (o_win_border) bord_n++;
                if (o_win_last) begin
                    last_n++; last_row = o_win_row; last_col = o_win_col;
                end
            end
            if (o_frame_done) done_n++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_rec();
        lbq.delete();
        win_n = 0; bord_n = 0; last_n = 0; done_n = 0;
    endtask

    // Drives vsync, a PAD_TOP-length gap (optional stray pixel at gap slot
    // bad_top), then N contiguous pixels 1..N (optional vsync at pixel vs_at).
    task automatic run_frame(input int vs_at, input int bad_top);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk("busy_after_vsync", o_busy, 1);
        chk("lb_idle_after_vsync", o_lb_valid, 0);
        for (int i = 0; i < RL; i++) begin
            pv = (i == bad_top);
            pd = 8'hAA;
            tick();
        end
        for (int p = 1; p <= N; p++) begin
            pv = 1'b1;
            pd = p[7:0];
            vsync = (p == vs_at);
            tick();
        end
        pv = 1'b0; pd = '0; vsync = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!o_frame_done && t < 200) begin
            tick();
            t++;
        end
        chk(name, t < 200, 1);
    endtask

    task automatic chk_stream(input string name);
        int n = (lbq.size() < 2 * RL + N) ? lbq.size() : 2 * RL + N;
        chk({name, "_len"}, lbq.size(), 2 * RL + N);
        for (int i = 0; i < n; i++)
            chk({name, "_data"}, lbq[i], (i < RL || i >= RL + N) ? 0 : i - RL + 1);
    endtask

    initial begin : stim
        repeat (2) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_lb_valid", o_lb_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_row", o_win_row, 0);
        rst = 1'b0;
        tick();

        // Clean frame
        clear_rec();
        run_frame(-1, -1);
        wait_done("f1_done_seen");
        tick();
        chk_stream("f1_stream");
        chk("f1_windows", win_n, 32);
        chk("f1_borders", bord_n, 20);
        chk("f1_lasts", last_n, 1);
        chk("f1_last_row", last_row, 3);
        chk("f1_last_col", last_col, 7);
        chk("f1_done_pulses", done_n, 1);
        chk("f1_err", o_err, 0);
        chk("f1_idle", o_busy, 0);

        // Stray camera pixel during the top pad
        clear_rec();
        run_frame(-1, 2);
        chk("f2_err_set", o_err, 1);
        wait_done("f2_done_seen");
        tick();
        chk_stream("f2_stream");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("f2_err_cleared", o_err, 0);

        // vsync mid-frame at pixel 10
        clear_rec();
        run_frame(10, -1);
        chk("f3_err_set", o_err, 1);
        wait_done("f3_done_seen");
        tick();
        chk_stream("f3_stream");
        chk("f3_windows", win_n, 32);
        chk("f3_done_pulses", done_n, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Async reset in the middle of ACTIVE
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (RL) tick();
        for (int p = 1; p <= 12; p++) begin
            pv = 1'b1; pd = p[7:0];
            tick();
        end
        pv = 1'b0;
        chk("pre_rst_col_moved", o_win_col != 0, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_lb_valid", o_lb_valid, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_row", o_win_row, 0);
        chk("rst_mid_col", o_win_col, 0);
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back frames, second vsync in the DONE cycle
        clear_rec();
        run_frame(-1, -1);
        wait_done("b2b_a_done_seen");
        run_frame(-1, -1);
        wait_done("b2b_b_done_seen");
        tick();
        chk("b2b_windows", win_n, 64);
        chk("b2b_done_pulses", done_n, 2);
        chk("b2b_lasts", last_n, 2);
        chk("b2b_lb_count", lbq.size(), 2 * (2 * RL + N));
        chk("b2b_err", o_err, 0);

        // Window while idle, with a simultaneous clear: set wins
        force_wv = 1'b1; err_clr = 1'b1;
        tick();
        force_wv = 1'b0; err_clr = 1'b0;
        chk("idle_win_err", o_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("idle_win_err_clr", o_err, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
